moka_rv32i_trace_buffer: RTL and testbench
==========================================

Name: moka_rv32i_trace_buffer

Overview:
- Parametrised successor to the passive internal-signal bind. It does not just observe the RV32I single-cycle datapath; it records it.
- Per retired instruction it captures a trace record: pc, instruction, WD3, rd, RegWrite, MemWrite and PCSrc. Records go into a circular buffer.
- Capture freezes a programmable number of entries after a trigger. The frozen window is then drained oldest-first over a valid/ready port.
- Instantiated by the testbench or debug wrapper alongside the core; it has no effect on core behaviour.

Parameters:
- DATA_WIDTH, 32, width of pc/instruction/write-back data.
- DEPTH, 16, number of trace entries; must be a power of 2 and at least 2.
- POST_TRIG, 4, entries captured after the triggering entry; legal range 0..DEPTH-1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- retire  in  1  an instruction commits this cycle; capture qualifier.
- pc  in  DATA_WIDTH  pc of the retiring instruction.
- instruction  in  DATA_WIDTH  fetched instruction word.
- WD3  in  DATA_WIDTH  register-file write data.
- ALUResult  in  DATA_WIDTH  ALU result; data-memory address on stores.
- rd  in  5  destination register.
- RegWrite, MemWrite, PCSrc  in  1 each  control signals.
- arm  in  1  pulse: clear the buffer and start capture.
- trig_mode  in  2  0 = pc match, 1 = store-address match, 2 = PCSrc taken, 3 = trig_force.
- trig_value  in  DATA_WIDTH  compare value for modes 0 and 1.
- trig_force  in  1  manual trigger used in mode 3.
- out_valid  out  1  a trace record is available.
- out_ready  in  1  consumer accepts the record.
- out_pc, out_instr, out_wdata  out  DATA_WIDTH  record fields.
- out_rd  out  5  record field.
- out_flags  out  3  {RegWrite, MemWrite, PCSrc} of the record.
- state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- triggered  out  1  the trigger has fired since the last arm.
- fill_count  out  $clog2(DEPTH)+1  valid entries held.

Behaviour:
- Reset (async, rst_n = 0):
  - State IDLE; wr_ptr, rd_ptr, fill_count and post_cnt are 0.
  - triggered = 0; out_valid = 0.
  - All out_* data are 0. Buffer RAM is not reset.
- Record outputs:
  - out_* data are driven combinationally from mem[rd_ptr] when out_valid = 1.
  - They are forced to 0 when out_valid = 0.
- arm = 1, any state:
  - Next state ARMED; wr_ptr, rd_ptr, fill_count and post_cnt cleared; triggered cleared.
  - arm has priority over capture, trigger and pop in the same cycle.
- IDLE: retire ignored; nothing is written.
- ARMED, retire = 1:
  - Write the record at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH.
  - fill_count increments, saturating at DEPTH. Older entries are overwritten once wrapped.
- Trigger evaluation:
  - Only in ARMED, only when retire = 1, evaluated on the same record being captured.
  - Mode 0: pc == trig_value.
  - Mode 1: MemWrite && ALUResult == trig_value.
  - Mode 2: PCSrc.
  - Mode 3: trig_force.
- On trigger:
  - The triggering record is itself written; triggered <= 1; post_cnt <= POST_TRIG.
  - Next state POST, or DONE directly if POST_TRIG == 0.
- POST:
  - Each retire writes a record, with the same pointer/saturation rules, and decrements post_cnt.
  - When the write makes post_cnt reach 0, the next state is DONE (same edge).
  - Further trigger conditions in POST are ignored. retire = 0 cycles write nothing and do not decrement.
- Entering DONE: rd_ptr <= (wr_ptr_next − fill_count_next) mod DEPTH, i.e. the oldest entry.
- DONE (draining):
  - Capture is disabled. out_valid = (fill_count != 0).
  - A pop occurs when out_valid && out_ready: rd_ptr increments mod DEPTH and fill_count decrements.
  - Records are presented oldest to newest.
  - When empty: out_valid = 0, state stays DONE, triggered stays 1 until the next arm.
  - out_ready with out_valid = 0 has no effect.
- Latency:
  - Capture and state change are visible one clock after the sampling edge.
  - out_* change combinationally with rd_ptr after each pop edge.
  - No trigger ever: the buffer keeps rolling in ARMED; out_valid stays 0.
- Reset mid-drain or mid-capture: immediate return to reset values; partial data is lost.
- Width rules:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - fill_count is $clog2(DEPTH)+1 bits so it can represent DEPTH.
  - post_cnt is $clog2(DEPTH) bits.

Test Plan:
- Reset then idle: retire = 1 for 10 cycles with no arm -> state = 0, fill_count = 0, out_valid = 0, all out_* = 0.
- DEPTH = 16, POST_TRIG = 4, mode 0, trig_value = 0x40:
  - Stimulus: arm, then retire pcs 0x00, 0x04, … continuously.
  - Trigger at 0x40; DONE after pc 0x50.
  - fill_count = 21 would exceed 16, so it saturates at 16.
  - Drain yields pc 0x14 through 0x50 in order; fill_count = 0 afterwards.
- Wrap with few entries: arm, 3 retires (pc 0x0/0x4/0x8), trigger at 0x8 in mode 2 via PCSrc = 1, POST_TRIG = 0 -> DONE immediately; drain gives 3 records starting at pc 0x0; out_flags[0] = 1 only on the third.
- Back-pressure: in DONE hold out_ready = 0 for 5 cycles -> out_valid = 1 and out_pc stable; then toggle out_ready every other cycle -> exactly one pop per ready-high cycle, no loss or duplication.
- Mode 1 store match: MemWrite = 1, ALUResult = 0x1000 = trig_value on the 6th retire -> triggered = 1 after that edge; a later second match is ignored; retire gaps in POST do not decrement post_cnt.
- Re-arm mid-drain: after 2 pops assert arm together with out_ready -> state ARMED, fill_count = 0, triggered = 0, no pop occurs. Separately, pull rst_n low during POST -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/moka_rv32i_trace_buffer_if.sv
// moka_rv32i_trace_buffer_if: record drain port of the trace buffer
// master (buffer): drives out_valid and the record fields, samples out_ready
// slave (consumer): samples the record, drives out_ready
interface moka_rv32i_trace_buffer_if #(parameter int DATA_WIDTH = 32);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic [4:0]            out_rd;
  logic [2:0]            out_flags;
  modport master (output out_valid, out_pc, out_instr, out_wdata, out_rd, out_flags, input out_ready);
  modport slave (input out_valid, out_pc, out_instr, out_wdata, out_rd, out_flags, output out_ready);
endinterface

// File: rtl/moka_rv32i_trace_buffer.sv
// moka_rv32i_trace_buffer: circular retire-trace recorder with trigger and oldest-first drain
// clk/rst_n: core clock, async active-low reset
// retire, pc, instruction, WD3, ALUResult, rd, RegWrite, MemWrite, PCSrc: core signals sampled per retire
// arm, trig_mode, trig_value, trig_force: capture control and trigger selection
// tr: record drain port (valid/ready); state, triggered, fill_count: status
module moka_rv32i_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    retire,
  input  logic [DATA_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0]   instruction,
  input  logic [DATA_WIDTH-1:0]   WD3,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic [4:0]              rd,
  input  logic                    RegWrite,
  input  logic                    MemWrite,
  input  logic                    PCSrc,
  input  logic                    arm,
  input  logic [1:0]              trig_mode,
  input  logic [DATA_WIDTH-1:0]   trig_value,
  input  logic                    trig_force,
  moka_rv32i_trace_buffer_if.master tr,
  output logic [1:0]              state,
  output logic                    triggered,
  output logic [$clog2(DEPTH):0]  fill_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 3 * DATA_WIDTH + 8;
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} st_t;
  st_t st, st_n;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rec;
  logic [AW-1:0] wr_ptr, wr_n, rd_ptr, rd_n, post_cnt, post_n;
  logic [CW-1:0] fill_n;
  logic match, cap, hit, valid, pop, trig_n;
  always_comb begin
    match  = trig_mode == 2'd0 ? pc == trig_value :
             trig_mode == 2'd1 ? MemWrite && ALUResult == trig_value :
             trig_mode == 2'd2 ? PCSrc : trig_force;
    cap    = retire && (st == ARMED || st == POST);
    hit    = retire && st == ARMED && match;
    valid  = st == DONE && fill_count != '0;
    pop    = valid && tr.out_ready;
    st_n   = arm ? ARMED :
             hit ? (POST_TRIG == 0 ? DONE : POST) :
             (st == POST && cap && post_cnt == AW'(1)) ? DONE : st;
    wr_n   = arm ? '0 : cap ? wr_ptr + AW'(1) : wr_ptr;
    fill_n = arm ? '0 :
             cap ? (fill_count == CW'(DEPTH) ? fill_count : fill_count + CW'(1)) :
             pop ? fill_count - CW'(1) : fill_count;
    post_n = arm ? '0 : hit ? AW'(POST_TRIG) : (st == POST && cap) ? post_cnt - AW'(1) : post_cnt;
    // On entry to DONE point at the oldest surviving entry; a full buffer wraps to wr_ptr itself.
    rd_n   = arm ? '0 :
             (st != DONE && st_n == DONE) ? wr_n - fill_n[AW-1:0] :
             pop ? rd_ptr + AW'(1) : rd_ptr;
    trig_n = !arm && (triggered || hit);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      fill_count <= '0;
      triggered  <= 1'b0;
    end else begin
      st         <= st_n;
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      post_cnt   <= post_n;
      fill_count <= fill_n;
      triggered  <= trig_n;
    end
  end
  always_ff @(posedge clk)
    if (cap && !arm) mem[wr_ptr] <= {pc, instruction, WD3, rd, RegWrite, MemWrite, PCSrc};
  assign rec          = mem[rd_ptr];
  assign state        = st;
  assign tr.out_valid = valid;
  assign {tr.out_pc, tr.out_instr, tr.out_wdata, tr.out_rd, tr.out_flags} = valid ? rec : '0;
endmodule

// File: tb/tb_moka_rv32i_trace_buffer.sv
// tb_moka_rv32i_trace_buffer: directed self-checking bench for the trace buffer
module tb_moka_rv32i_trace_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = '0, instruction = '0, wd3 = '0, alu = '0, trig_value = '0;
  logic [4:0]  rd = '0;
  logic        regwrite = 1'b0, memwrite = 1'b0, pcsrc = 1'b0;
  logic        arm = 1'b0, trig_force = 1'b0, ready = 1'b0;
  logic [1:0]  trig_mode = '0;
  logic [1:0]  state0, state1;
  logic        trig0, trig1;
  logic [4:0]  fill0, fill1;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  moka_rv32i_trace_buffer_if #(.DATA_WIDTH(32)) t0 ();
  moka_rv32i_trace_buffer_if #(.DATA_WIDTH(32)) t1 ();
  assign t0.out_ready = ready;
  assign t1.out_ready = ready;
  moka_rv32i_trace_buffer #(.DATA_WIDTH(32), .DEPTH(16), .POST_TRIG(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .retire(retire), .pc(pc), .instruction(instruction), .WD3(wd3),
    .ALUResult(alu), .rd(rd), .RegWrite(regwrite), .MemWrite(memwrite), .PCSrc(pcsrc), .arm(arm),
    .trig_mode(trig_mode), .trig_value(trig_value), .trig_force(trig_force), .tr(t0.master),
    .state(state0), .triggered(trig0), .fill_count(fill0));
  moka_rv32i_trace_buffer #(.DATA_WIDTH(32), .DEPTH(16), .POST_TRIG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .retire(retire), .pc(pc), .instruction(instruction), .WD3(wd3),
    .ALUResult(alu), .rd(rd), .RegWrite(regwrite), .MemWrite(memwrite), .PCSrc(pcsrc), .arm(arm),
    .trig_mode(trig_mode), .trig_value(trig_value), .trig_force(trig_force), .tr(t1.master),
    .state(state1), .triggered(trig1), .fill_count(fill1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ret(input logic [31:0] p, input logic ps, input logic mw, input logic [31:0] a);
    retire = 1'b1; pc = p; instruction = p ^ 32'hA5A5_0000; wd3 = p + 32'h100; rd = p[6:2];
    regwrite = 1'b1; pcsrc = ps; memwrite = mw; alu = a;
    tick();
    retire = 1'b0; pcsrc = 1'b0; memwrite = 1'b0;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    n_tests++;
    if ({state0, fill0, trig0, t0.out_valid} !== 9'd0) begin
      n_fail++; $display("FAIL reset_async got st=%0d fill=%0d trig=%0d v=%0d want 0", state0, fill0, trig0, t0.out_valid);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) ret(32'(i * 4), 1'b1, 1'b1, 32'h0);
    n_tests++;
    if (state0 !== 2'd0 || fill0 !== 5'd0) begin
      n_fail++; $display("FAIL idle_retire got st=%0d fill=%0d want 0 0", state0, fill0);
    end
    n_tests++;
    if ({t0.out_valid, t0.out_pc, t0.out_instr, t0.out_wdata, t0.out_rd, t0.out_flags} !== '0) begin
      n_fail++; $display("FAIL idle_outputs got v=%0d pc=%h want all zero", t0.out_valid, t0.out_pc);
    end
  endtask
  task automatic test_pc_match();
    logic [31:0] e;
    trig_mode = 2'd0; trig_value = 32'h40;
    do_arm();
    n_tests++;
    if (state0 !== 2'd1 || fill0 !== 5'd0 || trig0 !== 1'b0) begin
      n_fail++; $display("FAIL arm_state got st=%0d fill=%0d trig=%0d want 1 0 0", state0, fill0, trig0);
    end
    for (int i = 0; i <= 20; i++) begin
      ret(32'(i * 4), 1'b0, 1'b0, 32'h0);
      if (i == 15) begin
        n_tests++;
        if (state0 !== 2'd1 || trig0 !== 1'b0 || fill0 !== 5'd16) begin
          n_fail++; $display("FAIL pre_trigger got st=%0d trig=%0d fill=%0d want 1 0 16", state0, trig0, fill0);
        end
      end
      if (i == 16) begin
        n_tests++;
        if (state0 !== 2'd2 || trig0 !== 1'b1 || fill0 !== 5'd16) begin
          n_fail++; $display("FAIL trigger_pc got st=%0d trig=%0d fill=%0d want 2 1 16", state0, trig0, fill0);
        end
      end
      if (i == 19) begin
        n_tests++;
        if (state0 !== 2'd2) begin
          n_fail++; $display("FAIL post_hold got st=%0d want 2", state0);
        end
      end
    end
    n_tests++;
    if (state0 !== 2'd3 || fill0 !== 5'd16 || t0.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL done_pc got st=%0d fill=%0d v=%0d want 3 16 1", state0, fill0, t0.out_valid);
    end
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      e = 32'h14 + 32'(k * 4);
      n_tests++;
      if ({t0.out_valid, t0.out_pc, t0.out_instr, t0.out_wdata} !== {1'b1, e, e ^ 32'hA5A5_0000, e + 32'h100}) begin
        n_fail++; $display("FAIL drain_pc[%0d] got v=%0d pc=%h instr=%h wd=%h want pc=%h", k, t0.out_valid, t0.out_pc, t0.out_instr, t0.out_wdata, e);
      end
      tick();
    end
    ready = 1'b0;
    n_tests++;
    if (fill0 !== 5'd0 || t0.out_valid !== 1'b0 || t0.out_pc !== 32'h0 || state0 !== 2'd3 || trig0 !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty got fill=%0d v=%0d pc=%h st=%0d trig=%0d want 0 0 0 3 1", fill0, t0.out_valid, t0.out_pc, state0, trig0);
    end
  endtask
  task automatic test_few_entries();
    logic [2:0] ef;
    trig_mode = 2'd2;
    do_arm();
    ret(32'h0, 1'b0, 1'b0, 32'h0);
    ret(32'h4, 1'b0, 1'b0, 32'h0);
    ret(32'h8, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (state1 !== 2'd3 || fill1 !== 5'd3 || trig1 !== 1'b1) begin
      n_fail++; $display("FAIL few_done got st=%0d fill=%0d trig=%0d want 3 3 1", state1, fill1, trig1);
    end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ef = (k == 2) ? 3'b101 : 3'b100;
      n_tests++;
      if (t1.out_valid !== 1'b1 || t1.out_pc !== 32'(k * 4) || t1.out_flags !== ef) begin
        n_fail++; $display("FAIL few_drain[%0d] got v=%0d pc=%h flags=%b want pc=%h flags=%b", k, t1.out_valid, t1.out_pc, t1.out_flags, 32'(k * 4), ef);
      end
      tick();
    end
    ready = 1'b0;
    n_tests++;
    if (t1.out_valid !== 1'b0 || fill1 !== 5'd0) begin
      n_fail++; $display("FAIL few_empty got v=%0d fill=%0d want 0 0", t1.out_valid, fill1);
    end
  endtask
  task automatic test_back_pressure();
    int idx;
    trig_mode = 2'd0; trig_value = 32'h8;
    do_arm();
    for (int i = 0; i < 7; i++) ret(32'(i * 4), 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (state0 !== 2'd3 || fill0 !== 5'd7) begin
      n_fail++; $display("FAIL bp_done got st=%0d fill=%0d want 3 7", state0, fill0);
    end
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (t0.out_valid !== 1'b1 || t0.out_pc !== 32'h0) begin
        n_fail++; $display("FAIL bp_stall[%0d] got v=%0d pc=%h want 1 0", k, t0.out_valid, t0.out_pc);
      end
    end
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      ready = (k % 2) == 1;
      tick();
      if (ready) idx++;
      n_tests++;
      if (t0.out_valid !== (idx < 7) || t0.out_pc !== (idx < 7 ? 32'(idx * 4) : 32'h0) || fill0 !== 5'(7 - idx)) begin
        n_fail++; $display("FAIL bp_toggle[%0d] got v=%0d pc=%h fill=%0d want pc=%h fill=%0d", k, t0.out_valid, t0.out_pc, fill0, 32'(idx * 4), 7 - idx);
      end
    end
    ready = 1'b0;
  endtask
  task automatic test_store_match();
    trig_mode = 2'd1; trig_value = 32'h1000;
    do_arm();
    for (int i = 1; i <= 5; i++) ret(32'h100 + 32'(i * 4), i != 3, 1'b0 ? 1'b0 : (i != 3), (i == 3) ? 32'h1000 : 32'h2000);
    n_tests++;
    if (trig0 !== 1'b0 || state0 !== 2'd1) begin
      n_fail++; $display("FAIL store_pre got trig=%0d st=%0d want 0 1", trig0, state0);
    end
    ret(32'h118, 1'b0, 1'b1, 32'h1000);
    n_tests++;
    if (trig0 !== 1'b1 || state0 !== 2'd2) begin
      n_fail++; $display("FAIL store_trig got trig=%0d st=%0d want 1 2", trig0, state0);
    end
    ret(32'h11c, 1'b0, 1'b1, 32'h1000);
    tick(); tick(); tick();
    ret(32'h120, 1'b0, 1'b0, 32'h0);
    ret(32'h124, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (state0 !== 2'd2 || fill0 !== 5'd9) begin
      n_fail++; $display("FAIL store_gap got st=%0d fill=%0d want 2 9", state0, fill0);
    end
    ret(32'h128, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (state0 !== 2'd3 || fill0 !== 5'd10 || t0.out_pc !== 32'h104) begin
      n_fail++; $display("FAIL store_done got st=%0d fill=%0d pc=%h want 3 10 104", state0, fill0, t0.out_pc);
    end
  endtask
  task automatic test_rearm();
    ready = 1'b1;
    tick(); tick();
    n_tests++;
    if (fill0 !== 5'd8 || t0.out_pc !== 32'h10c) begin
      n_fail++; $display("FAIL rearm_pops got fill=%0d pc=%h want 8 10c", fill0, t0.out_pc);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0; ready = 1'b0;
    n_tests++;
    if (state0 !== 2'd1 || fill0 !== 5'd0 || trig0 !== 1'b0 || t0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rearm_state got st=%0d fill=%0d trig=%0d v=%0d want 1 0 0 0", state0, fill0, trig0, t0.out_valid);
    end
  endtask
  task automatic test_reset_mid_post();
    trig_mode = 2'd3;
    do_arm();
    ret(32'h200, 1'b0, 1'b0, 32'h0);
    trig_force = 1'b1;
    ret(32'h204, 1'b0, 1'b0, 32'h0);
    trig_force = 1'b0;
    ret(32'h208, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (state0 !== 2'd2 || trig0 !== 1'b1 || fill0 !== 5'd3) begin
      n_fail++; $display("FAIL force_post got st=%0d trig=%0d fill=%0d want 2 1 3", state0, trig0, fill0);
    end
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (state0 !== 2'd0 || trig0 !== 1'b0 || fill0 !== 5'd0 || t0.out_valid !== 1'b0 || t0.out_pc !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got st=%0d trig=%0d fill=%0d v=%0d want 0 0 0 0", state0, trig0, fill0, t0.out_valid);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (state0 !== 2'd0 || fill0 !== 5'd0) begin
      n_fail++; $display("FAIL post_reset_idle got st=%0d fill=%0d want 0 0", state0, fill0);
    end
  endtask
  initial begin
    test_reset();
    test_pc_match();
    test_few_entries();
    test_back_pressure();
    test_store_match();
    test_rearm();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
